// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset sequencer holding IR/A/B/ALUOut/MDR/NPC and driving every datapath control.
// 3-5 clocks per instruction; no backpressure, outputs are combinational from state and internal registers.
module mc_ctrl #(
   parameter logic [4:0] RA_REG  = 5'd31,
   parameter logic [3:0] ALU_ADD = 4'd0,
   parameter logic [3:0] ALU_SUB = 4'd1,
   parameter logic [3:0] ALU_OR  = 4'd2,
   parameter logic [3:0] ALU_LUI = 4'd3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr_in,
   input  logic [31:0] pc_in,
   input  logic [31:0] rd1,
   input  logic [31:0] rd2,
   input  logic [31:0] dm_rd,
   input  logic [31:0] alu_res,
   output logic        pc_we,
   output logic        jump_sign,
   output logic [31:0] jump_addr,
   output logic        gf_we,
   output logic [4:0]  gf_wa,
   output logic [31:0] gf_wd,
   output logic [4:0]  gf_ra1,
   output logic [4:0]  gf_ra2,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wd,
   output logic [3:0]  alu_op,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  state,
   output logic        instr_done,
   output logic        illegal
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_t;

   state_t      cur, nxt;
   logic [31:0] ir, a, b, alu_out, mdr, npc;

   logic [5:0]  opc, fn;
   logic        is_r, is_nop, is_addu, is_subu, is_jr;
   logic        is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
   logic        is_legal, is_alu_wb, beq_taken;
   logic [31:0] imm_z, imm_s, br_tgt, j_tgt;
   logic [4:0]  wb_wa;

   assign opc       = ir[31:26];
   assign fn        = ir[5:0];
   assign is_r      = (opc == 6'h00);
   assign is_nop    = (ir == 32'd0);
   assign is_addu   = is_r && (fn == 6'h21);
   assign is_subu   = is_r && (fn == 6'h23);
   assign is_jr     = is_r && (fn == 6'h08);
   assign is_ori    = (opc == 6'h0d);
   assign is_lui    = (opc == 6'h0f);
   assign is_lw     = (opc == 6'h23);
   assign is_sw     = (opc == 6'h2b);
   assign is_beq    = (opc == 6'h04);
   assign is_j      = (opc == 6'h02);
   assign is_jal    = (opc == 6'h03);
   assign is_legal  = is_nop | is_addu | is_subu | is_jr | is_ori | is_lui |
                      is_lw | is_sw | is_beq | is_j | is_jal;
   assign is_alu_wb = is_addu | is_subu | is_ori | is_lui;

   assign imm_z     = {16'd0, ir[15:0]};
   assign imm_s     = {{16{ir[15]}}, ir[15:0]};
   assign br_tgt    = npc + {{14{ir[15]}}, ir[15:0], 2'b00};
   assign j_tgt     = {npc[31:28], ir[25:0], 2'b00};
   assign beq_taken = is_beq && (a == b);
   assign wb_wa     = is_r ? ir[15:11] : ir[20:16];

   assign gf_ra1     = ir[25:21];
   assign gf_ra2     = ir[20:16];
   assign state      = cur;
   assign instr_done = pc_we;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur     <= FETCH;
         ir      <= 32'd0;
         a       <= 32'd0;
         b       <= 32'd0;
         alu_out <= 32'd0;
         mdr     <= 32'd0;
         npc     <= 32'd0;
      end else begin
         cur <= nxt;
         case (cur)
            FETCH: begin
               ir  <= instr_in;
               npc <= pc_in + 32'd4;
            end
            DECODE: begin
               a <= rd1;
               b <= rd2;
            end
            EXEC: alu_out <= alu_res;
            MEM:  if (is_lw) mdr <= dm_rd;
            default: ;
         endcase
      end
   end

   always_comb begin
      nxt       = FETCH;
      pc_we     = 1'b0;
      jump_sign = 1'b0;
      jump_addr = 32'd0;
      gf_we     = 1'b0;
      gf_wa     = 5'd0;
      gf_wd     = 32'd0;
      dm_we     = 1'b0;
      dm_addr   = 32'd0;
      dm_wd     = 32'd0;
      alu_op    = ALU_ADD;
      alu_a     = 32'd0;
      alu_b     = 32'd0;
      illegal   = 1'b0;
      case (cur)
         FETCH:  nxt = DECODE;
         DECODE: begin
            nxt     = EXEC;
            illegal = !is_legal;
         end
         EXEC: begin
            alu_a = a;
            if (is_addu) begin
               alu_b = b;
            end else if (is_subu) begin
               alu_op = ALU_SUB;
               alu_b  = b;
            end else if (is_ori) begin
               alu_op = ALU_OR;
               alu_b  = imm_z;
            end else if (is_lui) begin
               alu_op = ALU_LUI;
               alu_b  = imm_z;
            end else if (is_lw || is_sw) begin
               alu_b = imm_s;
            end
            if (is_alu_wb) begin
               nxt = WB;
            end else if (is_lw || is_sw) begin
               nxt = MEM;
            end else begin
               // branch/jump/nop/illegal instructions retire here
               pc_we = 1'b1;
               if (beq_taken) begin
                  jump_sign = 1'b1;
                  jump_addr = br_tgt;
               end else if (is_j || is_jal) begin
                  jump_sign = 1'b1;
                  jump_addr = j_tgt;
               end else if (is_jr) begin
                  jump_sign = 1'b1;
                  jump_addr = a;
               end
               if (is_jal) begin
                  gf_we = (RA_REG != 5'd0);
                  gf_wa = RA_REG;
                  gf_wd = npc;
               end
            end
         end
         MEM: begin
            dm_addr = alu_out;
            if (is_sw) begin
               dm_we = 1'b1;
               dm_wd = b;
               pc_we = 1'b1;
            end else begin
               nxt = WB;
            end
         end
         WB: begin
            pc_we = 1'b1;
            gf_wa = wb_wa;
            gf_wd = is_lw ? mdr : alu_out;
            gf_we = (wb_wa != 5'd0);
         end
         default: nxt = FETCH;
      endcase
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: behavioural datapath around the DUT plus an instruction-level ISA model checked every cycle.
module tb_mc_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] instr_in, pc_in, rd1, rd2, dm_rd, alu_res;
   logic        pc_we, jump_sign, gf_we, dm_we, instr_done, illegal;
   logic [31:0] jump_addr, gf_wd, dm_addr, dm_wd, alu_a, alu_b;
   logic [4:0]  gf_wa, gf_ra1, gf_ra2;
   logic [3:0]  alu_op;
   logic [2:0]  state;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mc_ctrl dut (
      .clk(clk), .reset(reset), .instr_in(instr_in), .pc_in(pc_in),
      .rd1(rd1), .rd2(rd2), .dm_rd(dm_rd), .alu_res(alu_res),
      .pc_we(pc_we), .jump_sign(jump_sign), .jump_addr(jump_addr),
      .gf_we(gf_we), .gf_wa(gf_wa), .gf_wd(gf_wd), .gf_ra1(gf_ra1), .gf_ra2(gf_ra2),
      .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .state(state), .instr_done(instr_done), .illegal(illegal)
   );

   // datapath surrounding the controller
   logic [31:0] im  [0:511] = '{default: 32'h0};
   logic [31:0] grf [0:31]  = '{default: 32'h0};
   logic [31:0] dm  [0:255] = '{default: 32'hDEADBEEF};
   logic [31:0] pc;

   assign instr_in = im[pc[10:2]];
   assign pc_in    = pc;
   assign rd1      = (gf_ra1 == 5'd0) ? 32'd0 : grf[gf_ra1];
   assign rd2      = (gf_ra2 == 5'd0) ? 32'd0 : grf[gf_ra2];
   assign dm_rd    = dm[dm_addr[9:2]];

   always_comb begin
      case (alu_op)
         4'd0:    alu_res = alu_a + alu_b;
         4'd1:    alu_res = alu_a - alu_b;
         4'd2:    alu_res = alu_a | alu_b;
         4'd3:    alu_res = alu_b << 16;
         default: alu_res = 32'd0;
      endcase
   end

   always @(posedge clk or posedge reset) begin
      if (reset)      pc <= 32'd0;
      else if (pc_we) pc <= jump_sign ? jump_addr : pc + 32'd4;
   end

   always @(posedge clk) begin
      if (gf_we) grf[gf_wa] <= gf_wd;
      if (dm_we) dm[dm_addr[9:2]] <= dm_wd;
   end

   // ISA-level reference model
   typedef struct {
      int          len;
      bit          ill, wr, mw, taken, has_mem, alu_used;
      logic [4:0]  wa, rs, rt;
      logic [31:0] wd, maddr, mwd, tgt, av, ab;
      logic [3:0]  aop;
   } pred_t;

   logic [31:0] m_grf [0:31]  = '{default: 32'h0};
   logic [31:0] m_dm  [0:255] = '{default: 32'hDEADBEEF};
   logic [31:0] m_pc = 32'd0;
   int          k = 0;

   function automatic pred_t predict(input logic [31:0] p);
      pred_t r;
      logic [31:0] ir, a, b, zx, sx, npc;
      ir = im[p[10:2]];
      r = '{default: 0};
      r.rs = ir[25:21];
      r.rt = ir[20:16];
      a = m_grf[r.rs];
      b = m_grf[r.rt];
      r.av = a;
      zx = {16'h0, ir[15:0]};
      sx = {{16{ir[15]}}, ir[15:0]};
      npc = p + 32'd4;
      r.len = 3;
      if (ir != 32'd0) begin
         case (ir[31:26])
            6'h00: case (ir[5:0])
               6'h21: begin r.len = 4; r.wr = 1; r.wa = ir[15:11]; r.wd = a + b;
                            r.alu_used = 1; r.aop = 4'd0; r.ab = b; end
               6'h23: begin r.len = 4; r.wr = 1; r.wa = ir[15:11]; r.wd = a - b;
                            r.alu_used = 1; r.aop = 4'd1; r.ab = b; end
               6'h08: begin r.taken = 1; r.tgt = a; end
               default: r.ill = 1;
            endcase
            6'h0d: begin r.len = 4; r.wr = 1; r.wa = r.rt; r.wd = a | zx;
                         r.alu_used = 1; r.aop = 4'd2; r.ab = zx; end
            6'h0f: begin r.len = 4; r.wr = 1; r.wa = r.rt; r.wd = {ir[15:0], 16'h0};
                         r.alu_used = 1; r.aop = 4'd3; r.ab = zx; end
            6'h23: begin r.len = 5; r.has_mem = 1; r.wr = 1; r.wa = r.rt; r.maddr = a + sx;
                         r.wd = m_dm[r.maddr[9:2]]; r.alu_used = 1; r.aop = 4'd0; r.ab = sx; end
            6'h2b: begin r.len = 4; r.has_mem = 1; r.mw = 1; r.maddr = a + sx; r.mwd = b;
                         r.alu_used = 1; r.aop = 4'd0; r.ab = sx; end
            6'h04: begin r.taken = (a == b); r.tgt = npc + (sx << 2); end
            6'h02: begin r.taken = 1; r.tgt = {npc[31:28], ir[25:0], 2'b00}; end
            6'h03: begin r.taken = 1; r.tgt = {npc[31:28], ir[25:0], 2'b00};
                         r.wr = 1; r.wa = 5'd31; r.wd = npc; end
            default: r.ill = 1;
         endcase
      end
      if (r.wa == 5'd0) r.wr = 0;
      return r;
   endfunction

   // architectural effects commit only when the final cycle's clock edge completes
   always @(posedge clk or posedge reset) begin
      pred_t p;
      if (reset) begin
         k = 0;
         m_pc = 32'd0;
      end else begin
         p = predict(m_pc);
         k = k + 1;
         if (k >= p.len) begin
            if (p.wr) m_grf[p.wa] = p.wd;
            if (p.mw) m_dm[p.maddr[9:2]] = p.mwd;
            m_pc = p.taken ? p.tgt : m_pc + 32'd4;
            k = 0;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at t=%0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      pred_t p;
      int    es;
      bit    fin, js, gwe, dwe;
      if (!reset) begin
         p   = predict(m_pc);
         es  = (k < 3) ? k : ((k == 3 && p.has_mem) ? 3 : 4);
         fin = (k == p.len - 1);
         js  = p.taken && fin;
         gwe = p.wr && fin;
         dwe = p.mw && fin;
         chk("state", state, es);
         chk("pc_we", pc_we, fin);
         chk("instr_done", instr_done, fin);
         chk("jump_sign", jump_sign, js);
         chk("jump_addr", jump_addr, js ? p.tgt : 32'd0);
         chk("gf_we", gf_we, gwe);
         if (gwe) begin
            chk("gf_wa", gf_wa, p.wa);
            chk("gf_wd", gf_wd, p.wd);
         end
         chk("dm_we", dm_we, dwe);
         if (dwe) chk("dm_wd", dm_wd, p.mwd);
         chk("dm_addr", dm_addr, (p.has_mem && k == 3) ? p.maddr : 32'd0);
         chk("illegal", illegal, p.ill && k == 1);
         if (k >= 1) begin
            chk("gf_ra1", gf_ra1, p.rs);
            chk("gf_ra2", gf_ra2, p.rt);
         end
         if (k == 2) begin
            chk("alu_a", alu_a, p.av);
            if (p.alu_used) begin
               chk("alu_op", alu_op, p.aop);
               chk("alu_b", alu_b, p.ab);
            end
         end else begin
            chk("alu_op_idle", alu_op, 32'd0);
            chk("alu_a_idle", alu_a, 32'd0);
            chk("alu_b_idle", alu_b, 32'd0);
         end
      end
   end

   initial begin
      int  loops;
      bit  seen_jal;
      bit  got_mem;
      im[0]   = 32'h34011234; // ori  $1,$0,0x1234
      im[1]   = 32'h00211021; // addu $2,$1,$1
      im[2]   = 32'hAC020004; // sw   $2,4($0)
      im[3]   = 32'h8C030004; // lw   $3,4($0)
      im[4]   = 32'h0C000100; // jal  0x400
      im[256] = 32'h03E00008; // jr   $31
      im[5]   = 32'h10220001; // beq  $1,$2,+1 (not taken)
      im[6]   = 32'hFC000000; // opcode 0x3f
      im[7]   = 32'h0000002A; // unsupported funct
      im[8]   = 32'h00000000; // nop
      im[9]   = 32'h00412023; // subu $4,$2,$1
      im[10]  = 32'h3C05ABCD; // lui  $5,0xABCD
      im[11]  = 32'h00210021; // addu $0,$1,$1
      im[12]  = 32'h0800000E; // j    0x38
      im[13]  = 32'h34060BAD; // ori  $6 (must be skipped)
      im[14]  = 32'h1021FFFF; // beq  $1,$1,-1

      #1 reset = 1'b1;
      #2;
      chk("rst_state", state, 32'd0);
      chk("rst_pc_we", pc_we, 32'd0);
      chk("rst_gf_we", gf_we, 32'd0);
      chk("rst_dm_we", dm_we, 32'd0);
      chk("rst_jump_addr", jump_addr, 32'd0);
      chk("rst_gf_ra1", gf_ra1, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_illegal", illegal, 32'd0);
      @(negedge clk);
      @(negedge clk);
      #1 reset = 1'b0;

      loops = 0;
      seen_jal = 0;
      for (int c = 0; c < 400 && loops < 2; c++) begin
         @(negedge clk);
         #1;
         if (pc == 32'h10 && state == 3'd2 && !seen_jal) begin
            seen_jal = 1;
            chk("jal_target", jump_addr, 32'h400);
            chk("jal_link", gf_wd, 32'h14);
         end
         if (pc == 32'h38 && state == 3'd2) begin
            loops++;
            if (loops == 2) chk("beq_self_target", jump_addr, 32'h38);
         end
      end
      chk("seg_a_loops", loops, 32'd2);
      chk("jal_seen", seen_jal, 32'd1);
      chk("r1", grf[1], 32'h00001234);
      chk("r2", grf[2], 32'h00002468);
      chk("r3", grf[3], 32'h00002468);
      chk("r4", grf[4], 32'h00001234);
      chk("r5", grf[5], 32'hABCD0000);
      chk("r6_skipped", grf[6], 32'h0);
      chk("r31", grf[31], 32'h00000014);
      chk("r0", grf[0], 32'h0);
      chk("dm1", dm[1], 32'h00002468);
      chk("model_r3", m_grf[3], 32'h00002468);

      reset = 1'b1;
      im[0] = 32'hAC040008; // sw $4,8($0)
      @(negedge clk);
      #1 reset = 1'b0;
      got_mem = 0;
      for (int c = 0; c < 20 && !got_mem; c++) begin
         @(negedge clk);
         #1;
         if (state == 3'd3) got_mem = 1;
      end
      chk("seg_b_mem_reached", got_mem, 32'd1);
      chk("seg_b_dm_we_before", dm_we, 32'd1);
      reset = 1'b1;
      #1;
      chk("abort_dm_we", dm_we, 32'd0);
      chk("abort_state", state, 32'd0);
      chk("abort_pc_we", pc_we, 32'd0);
      chk("abort_dm_addr", dm_addr, 32'd0);
      chk("abort_dm_wd", dm_wd, 32'd0);
      chk("abort_gf_ra2", gf_ra2, 32'd0);
      @(posedge clk);
      #1;
      chk("abort_no_write", dm[2], 32'hDEADBEEF);
      chk("abort_pc", pc, 32'd0);
      @(negedge clk);
      #1 reset = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      chk("restart_sw", dm[2], 32'h00001234);
      chk("model_dm2", m_dm[2], 32'h00001234);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
